// File: rtl/score_award_sequencer.sv
// score_award_sequencer: turns per-requester point awards into single-point increment pulses for a BCD score counter
//   clock/reset                 : rising-edge clock, asynchronous active-low reset
//   awardValid/awardReady       : per-requester award handshake (bit i = requester i)
//   awardPoints0/awardPoints1   : points offered by requester 0/1
//   counterReady/counterEnable  : handshake towards the score counter, one point per pulse
//   grantId                     : requester charged by the most recent pulse
//   busy                        : points still pending or a pulse sequence in flight
module score_award_sequencer #(
    parameter int POINTS_WIDTH  = 4,
    parameter int PENDING_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              awardValid,
    input  logic [POINTS_WIDTH-1:0] awardPoints0,
    input  logic [POINTS_WIDTH-1:0] awardPoints1,
    output logic [1:0]              awardReady,
    input  logic                    counterReady,
    output logic                    counterEnable,
    output logic                    grantId,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
    // Highest pending value that can still absorb a maximum award without wrapping
    localparam logic [PENDING_WIDTH-1:0] ready_limit =
        PENDING_WIDTH'((2 ** PENDING_WIDTH - 1) - (2 ** POINTS_WIDTH - 1));
    state_t                   state_q, state_d;
    logic [PENDING_WIDTH-1:0] pending0_q, pending0_d, pending1_q, pending1_d;
    logic                     sel_q, sel_d;
    logic                     grant_q, grant_d;
    logic                     ce_q, ce_d;
    logic                     nz0, nz1, pick, dec, acc0, acc1;
    // grant_q doubles as the round-robin "last grant" and the grantId output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending0_q <= '0;
            pending1_q <= '0;
            sel_q      <= 1'b1;
            grant_q    <= 1'b1;
            ce_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending0_q <= pending0_d;
            pending1_q <= pending1_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            ce_q       <= ce_d;
        end
    end
    always_comb begin
        nz0     = pending0_q != '0;
        nz1     = pending1_q != '0;
        // Alternate when both have points, otherwise serve whoever has them
        pick    = (nz0 && nz1) ? ~grant_q : nz1;
        state_d = state_q == IDLE  ? (((nz0 || nz1) && counterReady) ? PULSE : IDLE) :
                  state_q == PULSE ? WAIT :
                  (counterReady ? IDLE : WAIT);
        sel_d   = (state_q == IDLE && state_d == PULSE) ? pick : sel_q;
    end
    always_comb begin
        awardReady    = {pending1_q <= ready_limit, pending0_q <= ready_limit};
        busy          = (state_q != IDLE) || nz0 || nz1;
        counterEnable = ce_q;
        grantId       = grant_q;
        dec           = state_q == PULSE;
        acc0          = awardValid[0] && awardReady[0];
        acc1          = awardValid[1] && awardReady[1];
        // Accept and decrement may land on the same requester in the same edge
        pending0_d    = pending0_q + (acc0 ? PENDING_WIDTH'(awardPoints0) : '0)
                        - PENDING_WIDTH'(dec && !sel_q);
        pending1_d    = pending1_q + (acc1 ? PENDING_WIDTH'(awardPoints1) : '0)
                        - PENDING_WIDTH'(dec && sel_q);
        grant_d       = dec ? sel_q : grant_q;
        ce_d          = state_d == PULSE;
    end
endmodule
